system_top: RTL and testbench

SYSTEM_TOP -- requirements
Module: system_top

---
 rtl/system_top.sv | 159 +++++++++++++++
 tb/tb_system_top.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/system_top.sv
// VGA 640x480@60 colour-square display driven by a debounced GPIO byte loader.
// Define SYSTEM_TOP_COLORBARS_EN to replace the square with eight vertical colour bars.
module system_top #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned SQ_SIZE         = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] gpio1,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_blank_n,
  output logic        vga_clk,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] SQ_H0 = 10'(320 - SQ_SIZE / 2);
  localparam logic [9:0] SQ_H1 = 10'(320 + SQ_SIZE / 2);
  localparam logic [9:0] SQ_V0 = 10'(240 - SQ_SIZE / 2);
  localparam logic [9:0] SQ_V1 = 10'(240 + SQ_SIZE / 2);

  logic [8:0]      sync1, sync2;
  logic [7:0]      d_sync;
  logic            strobe_sync;
  logic            db_strobe;
  logic [DB_W-1:0] db_cnt;
  logic [7:0]      data;

  logic            tgl;
  logic [9:0]      h_cnt, v_cnt;

  logic            active;
  logic            hs_next, vs_next;
  logic [7:0]      r_next, g_next, b_next;
  logic            unused_bits;

  // Only gpio1[33:25] are used; sync index n corresponds to gpio1[n+25].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio1[33:25];
      sync2 <= sync1;
    end
  end

  assign strobe_sync = sync2[0];
  assign d_sync = {sync2[7], sync2[8], sync2[5], sync2[6],
                   sync2[3], sync2[4], sync2[1], sync2[2]};

  // db_cnt counts consecutive clks where the synced strobe differs from the accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt    <= '0;
      db_strobe <= 1'b0;
      data      <= '0;
    end else if (strobe_sync == db_strobe) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      db_strobe <= strobe_sync;
      if (strobe_sync)
        data <= d_sync;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // vga_clk trails tgl by one clk, so tgl=1 marks the clk on which vga_clk rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgl     <= 1'b0;
      vga_clk <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      tgl     <= ~tgl;
      vga_clk <= tgl;
      if (tgl) begin
        if (h_cnt == 10'd799) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'd524) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

`ifdef SYSTEM_TOP_COLORBARS_EN
  logic [2:0] bar;

  assign unused_bits = ^{gpio1[35:34], gpio1[24:0], data};

  always_comb begin
    bar     = 3'(h_cnt / 10'd80);
    active  = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    hs_next = !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
    vs_next = !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
    r_next  = {8{bar[2]}};
    g_next  = {8{bar[1]}};
    b_next  = {8{bar[0]}};
    if (!active) begin
      r_next = '0;
      g_next = '0;
      b_next = '0;
    end
  end
`else
  logic in_sq;

  assign unused_bits = ^{gpio1[35:34], gpio1[24:0]};

  always_comb begin
    active  = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    hs_next = !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
    vs_next = !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
    in_sq   = (h_cnt >= SQ_H0) && (h_cnt < SQ_H1) &&
              (v_cnt >= SQ_V0) && (v_cnt < SQ_V1);
    r_next  = 8'h20;
    g_next  = 8'h20;
    b_next  = 8'h20;
    if (in_sq) begin
      r_next = {data[7:5], data[7:5], data[7:6]};
      g_next = {data[4:2], data[4:2], data[4:3]};
      b_next = {4{data[1:0]}};
    end
    if (!active) begin
      r_next = '0;
      g_next = '0;
      b_next = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vga_blank_n <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      hsync       <= hs_next;
      vsync       <= vs_next;
      vga_blank_n <= active;
      r           <= r_next;
      g           <= g_next;
      b           <= b_next;
    end
  end

endmodule

// File: tb/tb_system_top.sv
// Directed bench for system_top: sync timing, debounced byte loading and pixel colours.
// Uses SQ_SIZE=464 (square h 88..551, v 8..471) so square rows are reached early in a frame.
module tb_system_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] gpio1;
  logic        hsync, vsync, vga_blank_n, vga_clk;
  logic [7:0]  r, g, b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc;

  system_top #(
    .DEBOUNCE_CYCLES(1000),
    .SQ_SIZE        (464)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio1      (gpio1),
    .hsync      (hsync),
    .vsync      (vsync),
    .vga_blank_n(vga_blank_n),
    .vga_clk    (vga_clk),
    .r          (r),
    .g          (g),
    .b          (b)
  );

  always #10 clk = ~clk;

  // Edge index since reset release: edge 1 is the first posedge with rst high.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic set_d(input logic [7:0] d);
    gpio1[32] = d[7];
    gpio1[33] = d[6];
    gpio1[30] = d[5];
    gpio1[31] = d[4];
    gpio1[28] = d[3];
    gpio1[29] = d[2];
    gpio1[26] = d[1];
    gpio1[27] = d[0];
  endtask

  // Park at the negedge following edge n.
  task automatic goto(input int n);
    if (cyc >= n) check("schedule", cyc, n - 1);
    while (cyc < n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_hs(input logic level, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (hsync === level) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Pixel k = v*800+h is presented by the output registers from edge 2k+1.
  task automatic pix(input string tag, input int h, input int v,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                     input logic eblank);
    goto(2 * (v * 800 + h) + 1);
    check({tag, ".r"}, r, er);
    check({tag, ".g"}, g, eg);
    check({tag, ".b"}, b, eb);
    check({tag, ".blank_n"}, vga_blank_n, eblank);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, ".hsync"}, hsync, 1'b1);
    check({tag, ".vsync"}, vsync, 1'b1);
    check({tag, ".blank_n"}, vga_blank_n, 1'b0);
    check({tag, ".vga_clk"}, vga_clk, 1'b0);
    check({tag, ".rgb"}, {r, g, b}, 24'h0);
  endtask

  initial begin
    int at;
    gpio1 = 36'h0;
    gpio1[5] = 1'b1;
    gpio1[35] = 1'b1;

    #1 rst = 1'b0;
    #2 reset_vals("rst");
    #3 rst = 1'b1;

    wait_hs(1'b0, 3000, at);
    check("hs_first_fall", at, 1313);
    check("vga_clk_odd", vga_clk, 1'b0);
    @(negedge clk);
    check("vga_clk_even", vga_clk, 1'b1);
    wait_hs(1'b1, 400, at);
    check("hs_rise", at, 1313 + 192);
    wait_hs(1'b0, 2000, at);
    check("hs_second_fall", at, 1313 + 1600);
    check("vsync_idle", vsync, 1'b1);

    goto(3000);
    set_d(8'hFC);
    gpio1[25] = 1'b1;
    pix("v7_above_sq", 300, 7, 8'h20, 8'h20, 8'h20, 1'b1);
    goto(13000);
    gpio1[25] = 1'b0;
    pix("v8_sq_top", 300, 8, 8'hFF, 8'hFF, 8'h00, 1'b1);
    pix("outside", 10, 10, 8'h20, 8'h20, 8'h20, 1'b1);
    pix("sq_fc", 300, 10, 8'hFF, 8'hFF, 8'h00, 1'b1);
    pix("h639", 639, 10, 8'h20, 8'h20, 8'h20, 1'b1);
    pix("h640_blank", 640, 10, 8'h00, 8'h00, 8'h00, 1'b0);
    pix("hblank", 700, 10, 8'h00, 8'h00, 8'h00, 1'b0);

    goto(17500);
    set_d(8'h03);
    gpio1[25] = 1'b1;
    goto(18000);
    gpio1[25] = 1'b0;
    pix("short_pulse_a", 300, 11, 8'hFF, 8'hFF, 8'h00, 1'b1);
    pix("short_pulse_b", 300, 12, 8'hFF, 8'hFF, 8'h00, 1'b1);

    goto(19900);
    gpio1[25] = 1'b1;
    goto(21900);
    gpio1[25] = 1'b0;
    pix("long_pulse_03", 300, 15, 8'h00, 8'h00, 8'hFF, 1'b1);

    goto(24700);
    set_d(8'hFC);
    gpio1[25] = 1'b1;
    goto(26200);
    set_d(8'h03);
    goto(27200);
    gpio1[25] = 1'b0;
    pix("h87_left", 87, 18, 8'h20, 8'h20, 8'h20, 1'b1);
    pix("h88_sq_left", 88, 18, 8'hFF, 8'hFF, 8'h00, 1'b1);
    pix("held_change", 300, 18, 8'hFF, 8'hFF, 8'h00, 1'b1);
    pix("h551_sq_right", 551, 18, 8'hFF, 8'hFF, 8'h00, 1'b1);
    pix("h552_right", 552, 18, 8'h20, 8'h20, 8'h20, 1'b1);

    goto(30000);
    rst = 1'b0;
    #2 reset_vals("mid_rst");
    #3 rst = 1'b1;
    wait_hs(1'b0, 3000, at);
    check("hs_fall_after_rst", at, 1313);
    pix("rst_outside", 10, 8, 8'h20, 8'h20, 8'h20, 1'b1);
    pix("rst_sq_cleared", 300, 8, 8'h00, 8'h00, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
